// File: rtl/spi_arb_pkg.sv
// Shared state and command encodings for the SPI RAM arbiter.
package spi_arb_pkg;

   localparam int CMD_W = 10;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_LOCKED,
      ARB_WAIT_RD
   } arb_state_e;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } spi_cmd_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   always_comb begin
      int idx;
      gnt = '0;
      // Walk from the farthest offset down so the nearest hit wins.
      for (int k = N; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N;
         if ((req & (ONE << idx)) != '0) gnt = ONE << idx;
      end
   end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates NUM_REQ command streams onto one SPI RAM port with an
// address-to-data lock and read-response routing back to the issuer.
module spi_ram_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int CMD_W        = 10,
   parameter int LOCK_TIMEOUT = 64
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*CMD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [7:0]               rsp_data,
   output logic [CMD_W-1:0]         ram_din,
   output logic                     ram_rx_valid,
   input  logic [7:0]               ram_dout,
   input  logic                     ram_tx_valid,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     lock_timeout
);

   import spi_arb_pkg::*;

   localparam int PW = $clog2(NUM_REQ);
   localparam int TW = $clog2(LOCK_TIMEOUT);

   arb_state_e           state_q, state_d;
   spi_cmd_e             exp_q, exp_d, cmd;
   logic [PW-1:0]        owner_q, owner_d, rr_q, rr_d, pick_idx;
   logic [NUM_REQ-1:0]   pick, grant_d;
   logic [TW-1:0]        tmr_q;
   logic [CMD_W-1:0]     word;
   logic                 accept, rsp_fire, timeout, tmr_hit;

   rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
      .req (req_valid),
      .ptr (rr_q),
      .gnt (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) if (pick[i]) pick_idx = PW'(i);
   end

   assign word    = req_data[int'(owner_q)*CMD_W +: CMD_W];
   assign cmd     = spi_cmd_e'(word[CMD_W-1 -: 2]);
   assign tmr_hit = (tmr_q == TW'(LOCK_TIMEOUT-1));

   always_comb begin
      req_ready = '0;
      if (state_q == ARB_ISSUE || state_q == ARB_LOCKED) req_ready = req_valid & grant;
   end
   assign accept = |req_ready;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      exp_d    = exp_q;
      grant_d  = grant;
      rsp_fire = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (|req_valid) begin
               grant_d = pick;
               owner_d = pick_idx;
               state_d = ARB_ISSUE;
            end
         end
         ARB_ISSUE, ARB_LOCKED: begin
            if (accept) begin
               case (cmd)
                  CMD_WR_ADDR: begin state_d = ARB_LOCKED; exp_d = CMD_WR_DATA; end
                  CMD_RD_ADDR: begin state_d = ARB_LOCKED; exp_d = CMD_RD_DATA; end
                  default: begin
                     // A data phase that disagrees with the locked address just releases.
                     if (cmd == CMD_RD_DATA && !(state_q == ARB_LOCKED && exp_q != CMD_RD_DATA)) begin
                        state_d = ARB_WAIT_RD;
                     end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        rr_d    = owner_q;
                     end
                  end
               endcase
            end else if (state_q == ARB_LOCKED && tmr_hit) begin
               timeout = 1'b1;
               state_d = ARB_IDLE;
               grant_d = '0;
               rr_d    = owner_q;
            end
         end
         ARB_WAIT_RD: begin
            if (ram_tx_valid || tmr_hit) begin
               rsp_fire = ram_tx_valid;
               timeout  = !ram_tx_valid;
               state_d  = ARB_IDLE;
               grant_d  = '0;
               rr_d     = owner_q;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         exp_q        <= CMD_WR_DATA;
         owner_q      <= '0;
         rr_q         <= PW'(NUM_REQ-1);
         tmr_q        <= '0;
         grant        <= '0;
         ram_din      <= '0;
         ram_rx_valid <= 1'b0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         lock_timeout <= 1'b0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         owner_q      <= owner_d;
         rr_q         <= rr_d;
         grant        <= grant_d;
         ram_rx_valid <= accept;
         if (accept) ram_din <= word;
         rsp_valid    <= rsp_fire ? grant : '0;
         if (rsp_fire) rsp_data <= ram_dout;
         lock_timeout <= timeout;
         if (accept || state_d != state_q) tmr_q <= '0;
         else if (state_q == ARB_LOCKED || state_q == ARB_WAIT_RD) tmr_q <= tmr_q + TW'(1);
      end
   end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter with two requesters and a short lock timeout.
module tb_spi_ram_arbiter;

   localparam int N  = 2;
   localparam int CW = 10;

   logic            CLK = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*CW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [7:0]      rsp_data;
   logic [CW-1:0]   ram_din;
   logic            ram_rx_valid;
   logic [7:0]      ram_dout;
   logic            ram_tx_valid;
   logic [N-1:0]    grant;
   logic            lock_timeout;

   spi_ram_arbiter #(.NUM_REQ(N), .CMD_W(CW), .LOCK_TIMEOUT(8)) dut (
      .CLK          (CLK),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid),
      .grant        (grant),
      .lock_timeout (lock_timeout)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int passed = 0;

   logic [CW-1:0] q0[$], q1[$], exp_rx[$];
   logic [9:0]    exp_rsp[$];
   int            dly0 = 0, dly1 = 0;
   bit            tx_now = 1'b0;
   logic [7:0]    tx_data = 8'h00;
   int            cyc = 0, acc_cyc0 = 0, lt_cnt = 0, lt_cyc = 0, rsp_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic monitor();
      logic [CW-1:0] e;
      logic [9:0]    r;
      check("grant_onehot", 32'($onehot0(grant)), 1);
      if (ram_rx_valid) begin
         if (exp_rx.size() == 0) check("rx_unexpected", 32'(ram_rx_valid), 0);
         else begin
            e = exp_rx.pop_front();
            check("ram_din", 32'(ram_din), 32'(e));
         end
      end
      if (rsp_valid != '0) begin
         rsp_cnt++;
         if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
         else begin
            r = exp_rsp.pop_front();
            check("rsp", 32'({rsp_valid, rsp_data}), 32'(r));
         end
      end
      if (lock_timeout) begin
         lt_cnt++;
         lt_cyc = cyc;
      end
   endtask

   // One clock: check outputs at the falling edge, drive, then cross the rising edge.
   task automatic step();
      logic v0, v1, a0, a1;
      monitor();
      v0 = (q0.size() > 0) && (dly0 == 0);
      v1 = (q1.size() > 0) && (dly1 == 0);
      req_valid    = {v1, v0};
      req_data     = {v1 ? q1[0] : 10'h000, v0 ? q0[0] : 10'h000};
      ram_tx_valid = tx_now;
      ram_dout     = tx_now ? tx_data : 8'h00;
      #1;
      a0 = v0 & req_ready[0];
      a1 = v1 & req_ready[1];
      if (a0) acc_cyc0 = cyc;
      @(posedge CLK);
      cyc++;
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      if (dly0 > 0) dly0--;
      if (dly1 > 0) dly1--;
      tx_now = 1'b0;
      @(negedge CLK);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0) && n < 300) begin
         step();
         n++;
      end
      check("drain_done", 32'(q0.size() + q1.size()), 0);
   endtask

   initial begin
      int lt0, rs0;
      rst = 1'b1;
      req_valid = '0;
      req_data = '0;
      ram_dout = '0;
      ram_tx_valid = 1'b0;
      @(negedge CLK);
      steps(3);
      check("rst_grant", 32'(grant), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rx_valid", 32'(ram_rx_valid), 0);
      check("rst_lock_timeout", 32'(lock_timeout), 0);
      check("rst_ram_din", 32'(ram_din), 0);
      rst = 1'b0;

      // Single write, then a stray RAM strobe while idle.
      q0 = '{10'h0A5, 10'h13C};
      exp_rx = '{10'h0A5, 10'h13C};
      drain();
      check("t1_grant_released", 32'(grant), 0);
      tx_now = 1'b1;
      tx_data = 8'h77;
      steps(3);
      check("t1_rx_left", 32'(exp_rx.size()), 0);
      check("t1_stray_rsp", 32'(rsp_cnt), 0);

      // Read back by requester 1.
      q1 = '{10'h2A5, 10'h300};
      exp_rx = '{10'h2A5, 10'h300};
      drain();
      steps(2);
      exp_rsp.push_back({2'b10, 8'h3C});
      tx_now = 1'b1;
      tx_data = 8'h3C;
      steps(4);
      check("t2_rsp_count", 32'(rsp_cnt), 1);
      check("t2_rsp_left", 32'(exp_rsp.size()), 0);
      check("t2_rx_left", 32'(exp_rx.size()), 0);

      // Lock hold: requester 1 must wait for requester 0's data phase.
      q0 = '{10'h011, 10'h122};
      q1 = '{10'h0FF, 10'h1FF};
      dly1 = 1;
      exp_rx = '{10'h011, 10'h122, 10'h0FF, 10'h1FF};
      drain();
      steps(3);
      check("t3_rx_left", 32'(exp_rx.size()), 0);

      // Round-robin with continuous write pairs from both.
      q0 = '{10'h001, 10'h101, 10'h002, 10'h102};
      q1 = '{10'h0F1, 10'h1F1, 10'h0F2, 10'h1F2};
      exp_rx = '{10'h001, 10'h101, 10'h0F1, 10'h1F1, 10'h002, 10'h102, 10'h0F2, 10'h1F2};
      drain();
      steps(3);
      check("t4_rx_left", 32'(exp_rx.size()), 0);

      // Lock timeout after an abandoned read address.
      lt0 = lt_cnt;
      rs0 = rsp_cnt;
      q0 = '{10'h2A5};
      q1 = '{10'h0C3, 10'h1C3};
      dly1 = 1;
      exp_rx = '{10'h2A5, 10'h0C3, 10'h1C3};
      drain();
      steps(3);
      check("t5_timeout_count", 32'(lt_cnt - lt0), 1);
      check("t5_timeout_delay", 32'(lt_cyc - (acc_cyc0 + 1)), 8);
      check("t5_no_rsp", 32'(rsp_cnt - rs0), 0);
      check("t5_rx_left", 32'(exp_rx.size()), 0);

      // Reset during a pending read by requester 0.
      rs0 = rsp_cnt;
      q0 = '{10'h2A5, 10'h300};
      exp_rx = '{10'h2A5, 10'h300};
      drain();
      steps(2);
      rst = 1'b1;
      tx_now = 1'b1;
      tx_data = 8'h5A;
      steps(2);
      check("t6_grant", 32'(grant), 0);
      check("t6_rsp_valid", 32'(rsp_valid), 0);
      check("t6_rsp_data", 32'(rsp_data), 0);
      check("t6_rx_valid", 32'(ram_rx_valid), 0);
      check("t6_ram_din", 32'(ram_din), 0);
      check("t6_lock_timeout", 32'(lock_timeout), 0);
      rst = 1'b0;
      steps(2);
      check("t6_no_rsp", 32'(rsp_cnt - rs0), 0);
      q0 = '{10'h0AA, 10'h1AA};
      q1 = '{10'h0BB, 10'h1BB};
      exp_rx = '{10'h0AA, 10'h1AA, 10'h0BB, 10'h1BB};
      drain();
      steps(3);
      check("t6_rx_left", 32'(exp_rx.size()), 0);
      check("end_rsp_left", 32'(exp_rsp.size()), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
